// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - track-sensor synchronizer, debounce, rise pulses and stuck detect
module sensor_conditioner #(
    parameter int N_SENS       = 4,
    parameter int DEB_CYCLES   = 4,
    parameter int DEB_W        = 3,
    parameter int STUCK_CYCLES = 64,
    parameter int STUCK_W      = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_SENS-1:0] i_raw,
    input  logic              i_stuck_clr,
    output logic [N_SENS-1:0] o_sr,
    output logic [N_SENS-1:0] o_sr_rise,
    output logic [N_SENS-1:0] o_stuck
);

    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STK_MAX  = STUCK_W'(STUCK_CYCLES);

    logic [N_SENS-1:0]  r_sy1;
    logic [N_SENS-1:0]  r_sy2;
    logic [N_SENS-1:0]  r_sr;
    logic [N_SENS-1:0]  r_sr_rise;
    logic [N_SENS-1:0]  r_stuck;
    logic [DEB_W-1:0]   r_deb_cnt [N_SENS];
    logic [STUCK_W-1:0] r_stk_cnt [N_SENS];

    logic [N_SENS-1:0]  w_sr_next;
    logic [N_SENS-1:0]  w_stk_set;
    logic [DEB_W-1:0]   w_deb_next [N_SENS];
    logic [STUCK_W-1:0] w_stk_next [N_SENS];

    always_comb begin
        w_sr_next = r_sr;
        w_stk_set = '0;
        for (int i = 0; i < N_SENS; i++) begin
            w_deb_next[i] = '0;
            w_stk_next[i] = '0;
            // Count consecutive synced samples that disagree with the current level.
            if (r_sy2[i] != r_sr[i]) begin
                if (r_deb_cnt[i] == DEB_LAST) begin
                    w_sr_next[i] = r_sy2[i];
                end else begin
                    w_deb_next[i] = r_deb_cnt[i] + 1'b1;
                end
            end
            if (r_sr[i]) begin
                w_stk_next[i] = (r_stk_cnt[i] == STK_MAX) ? STK_MAX : r_stk_cnt[i] + 1'b1;
                w_stk_set[i]  = (w_stk_next[i] == STK_MAX);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sy1     <= '0;
            r_sy2     <= '0;
            r_sr      <= '0;
            r_sr_rise <= '0;
            r_stuck   <= '0;
            for (int i = 0; i < N_SENS; i++) begin
                r_deb_cnt[i] <= '0;
                r_stk_cnt[i] <= '0;
            end
        end else begin
            r_sy1     <= i_raw;
            r_sy2     <= r_sy1;
            r_sr      <= w_sr_next;
            r_sr_rise <= w_sr_next & ~r_sr;
            // Clear wins over a same-edge set; a saturated counter re-sets on the next edge.
            r_stuck   <= i_stuck_clr ? '0 : (r_stuck | w_stk_set);
            for (int i = 0; i < N_SENS; i++) begin
                r_deb_cnt[i] <= w_deb_next[i];
                r_stk_cnt[i] <= w_stk_next[i];
            end
        end
    end

    assign o_sr      = r_sr;
    assign o_sr_rise = r_sr_rise;
    assign o_stuck   = r_stuck;

endmodule
